// File: rtl/serial_addsub_pkg.sv
// Shared types and sizing helpers for the bit-serial adder/subtractor.
// Imported by the top and its full-adder cell.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 64;

  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// Single-bit full adder: the only arithmetic in the serial datapath.
// Purely combinational; the carry is registered by the parent.
module fa_cell
  import serial_addsub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: one result bit per clock through fa_cell.
// Operands and result move over two valid/ready handshakes.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("serial_addsub: WIDTH out of range");
  end

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             cout_q;
  logic             ovf_q;
  logic             fa_s;
  logic             fa_co;
  logic             last;

  fa_cell u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry),
    .s   (fa_s),
    .cout(fa_co)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == S_IDLE): begin
          if (in_valid) begin
            // Subtract as a + ~b + 1: the +1 enters as the initial carry.
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        (state == S_RUN): begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {fa_s, res_sr[WIDTH-1:1]};
          carry  <= fa_co;
          cnt    <= cnt + 1'b1;
          if (last) begin
            cout_q <= fa_co;
            ovf_q  <= carry ^ fa_co;
            state  <= S_DONE;
          end
        end
        (state == S_DONE): begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign sum       = res_sr;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub at WIDTH 2, 8 and 33 with directed and random ops.
// Expected results come from plain-arithmetic a+/-b.
module tb_serial_addsub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] a_in;
  logic [63:0] b_in;
  logic        sub_in;
  logic        in_valid;
  logic        out_ready;
  int          sel;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  logic iv0, iv1, iv2, or0, or1, or2;
  assign iv0 = in_valid && (sel == 0);
  assign iv1 = in_valid && (sel == 1);
  assign iv2 = in_valid && (sel == 2);
  assign or0 = out_ready && (sel == 0);
  assign or1 = out_ready && (sel == 1);
  assign or2 = out_ready && (sel == 2);

  logic        ir0, ov0, co0, of0, bz0;
  logic        ir1, ov1, co1, of1, bz1;
  logic        ir2, ov2, co2, of2, bz2;
  logic [1:0]  s0;
  logic [7:0]  s1;
  logic [32:0] s2;

  serial_addsub #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv0), .in_ready(ir0),
    .a(a_in[1:0]), .b(b_in[1:0]), .sub(sub_in),
    .out_valid(ov0), .out_ready(or0),
    .sum(s0), .cout(co0), .ovf(of0), .busy(bz0)
  );

  serial_addsub #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv1), .in_ready(ir1),
    .a(a_in[7:0]), .b(b_in[7:0]), .sub(sub_in),
    .out_valid(ov1), .out_ready(or1),
    .sum(s1), .cout(co1), .ovf(of1), .busy(bz1)
  );

  serial_addsub #(.WIDTH(33)) u_w33 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv2), .in_ready(ir2),
    .a(a_in[32:0]), .b(b_in[32:0]), .sub(sub_in),
    .out_valid(ov2), .out_ready(or2),
    .sum(s2), .cout(co2), .ovf(of2), .busy(bz2)
  );

  logic        m_ir, m_ov, m_co, m_of, m_bz;
  logic [63:0] m_sum;

  always_comb begin
    m_ir  = 1'b0;
    m_ov  = 1'b0;
    m_co  = 1'b0;
    m_of  = 1'b0;
    m_bz  = 1'b0;
    m_sum = '0;
    case (sel)
      0: begin
        m_ir = ir0; m_ov = ov0; m_co = co0;
        m_of = of0; m_bz = bz0; m_sum = 64'(s0);
      end
      1: begin
        m_ir = ir1; m_ov = ov1; m_co = co1;
        m_of = of1; m_bz = bz1; m_sum = 64'(s1);
      end
      default: begin
        m_ir = ir2; m_ov = ov2; m_co = co2;
        m_of = of2; m_bz = bz2; m_sum = 64'(s2);
      end
    endcase
  end

  function automatic int wof(input int k);
    return (k == 0) ? 2 : (k == 1) ? 8 : 33;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: exact integer arithmetic, then reduce modulo 2^w.
  task automatic model(input int w, input logic [63:0] a, b,
                       input logic s, output logic [63:0] es,
                       output logic ec, output logic eo);
    logic [63:0] mask;
    logic [64:0] full;
    longint sa, sb, r, mx, mn;
    mask = (64'd1 << w) - 64'd1;
    if (!s) begin
      full = {1'b0, a} + {1'b0, b};
      ec   = full[w];
      es   = full[63:0] & mask;
    end else begin
      ec = (a >= b);
      es = (a - b) & mask;
    end
    sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    r  = s ? sa - sb : sa + sb;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -(longint'(1) << (w - 1));
    eo = (r > mx) || (r < mn);
  endtask

  // Accept one op, scramble inputs, then check latency and result.
  task automatic start_op(input int k, input logic [63:0] a, b,
                          input logic s, input logic [63:0] es,
                          input logic ec, input logic eo);
    int n;
    sel = k;
    #1;
    n = 0;
    while (!m_ir && n < 100) begin
      tick;
      n++;
    end
    chk("in_ready_before_accept", 64'(m_ir), 64'd1);
    a_in = a; b_in = b; sub_in = s;
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick;
    in_valid = 1'b0;
    a_in = {$urandom, $urandom};
    b_in = {$urandom, $urandom};
    sub_in = ~s;
    n = 0;
    while (!m_ov && n < wof(k) + 10) begin
      tick;
      n++;
    end
    chk("latency", 64'(n), 64'(wof(k)));
    chk("sum", m_sum, es);
    chk("cout", 64'(m_co), 64'(ec));
    chk("ovf", 64'(m_of), 64'(eo));
  endtask

  task automatic finish_op(input int holds, input logic [63:0] es);
    for (int i = 0; i < holds; i++) begin
      out_ready = 1'b0;
      tick;
      chk("hold_valid", 64'(m_ov), 64'd1);
      chk("hold_sum", m_sum, es);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("in_ready_after_out", 64'(m_ir), 64'd1);
    chk("out_valid_cleared", 64'(m_ov), 64'd0);
  endtask

  task automatic directed(input logic [7:0] a, b, input logic s,
                          input logic [7:0] es, input logic ec,
                          input logic eo);
    start_op(1, 64'(a), 64'(b), s, 64'(es), ec, eo);
    finish_op(0, 64'(es));
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] ra, rb, es, mask;
    logic rs, ec, eo;
    int w;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a_in = '0;
    b_in = '0;
    sub_in = 1'b0;
    sel = 0;
    repeat (2) tick;
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      chk("rst_in_ready", 64'(m_ir), 64'd1);
      chk("rst_out_valid", 64'(m_ov), 64'd0);
      chk("rst_busy", 64'(m_bz), 64'd0);
      chk("rst_sum", m_sum, 64'd0);
      chk("rst_cout_ovf", {62'd0, m_co, m_of}, 64'd0);
    end
    rst_n = 1'b1;
    tick;

    directed(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    directed(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    directed(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
    directed(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    directed(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

    // Backpressure with competing in_valid pulses.
    start_op(1, 64'h5A, 64'h3C, 1'b0, 64'h96, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      out_ready = 1'b0;
      in_valid = (i % 2 == 0);
      a_in = 64'h11;
      b_in = 64'h22;
      tick;
      chk("bp_valid", 64'(m_ov), 64'd1);
      chk("bp_in_ready", 64'(m_ir), 64'd0);
      chk("bp_sum", m_sum, 64'h96);
      chk("bp_flags", {62'd0, m_co, m_of}, 64'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("bp_release_in_ready", 64'(m_ir), 64'd1);
    chk("bp_release_valid", 64'(m_ov), 64'd0);
    chk("bp_release_busy", 64'(m_bz), 64'd0);
    tick;
    chk("bp_not_taken", 64'(m_bz), 64'd0);

    // Reset during the third RUN cycle.
    sel = 1;
    a_in = 64'h5A;
    b_in = 64'h3C;
    sub_in = 1'b0;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    chk("pre_reset_busy", 64'(m_bz), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_sum", m_sum, 64'd0);
    chk("mid_rst_flags", {62'd0, m_co, m_of}, 64'd0);
    chk("mid_rst_valid", 64'(m_ov), 64'd0);
    chk("mid_rst_busy", 64'(m_bz), 64'd0);
    chk("mid_rst_in_ready", 64'(m_ir), 64'd1);
    tick;
    rst_n = 1'b1;
    tick;
    chk("post_rst_in_ready", 64'(m_ir), 64'd1);
    directed(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    // Random regression against the arithmetic model.
    for (int k = 0; k < 3; k++) begin
      w = wof(k);
      mask = (64'd1 << w) - 64'd1;
      for (int i = 0; i < 1000; i++) begin
        ra = {$urandom, $urandom} & mask;
        rb = {$urandom, $urandom} & mask;
        rs = 1'($urandom_range(0, 1));
        model(w, ra, rb, rs, es, ec, eo);
        start_op(k, ra, rb, rs, es, ec, eo);
        finish_op(($urandom_range(0, 3) == 0) ? 1 : 0, es);
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
